// File: rtl/game_fsm.sv
// Game sequencer: steps IDLE/PLAY/HIT/CLEAR/OVER on frame-paced pauses and
// issues the round/new-game reload pulses plus the current wave level.
module game_fsm #(
  parameter int unsigned HIT_FRAMES   = 32'd60,
  parameter int unsigned CLEAR_FRAMES = 32'd90,
  parameter int unsigned OVER_FRAMES  = 32'd120,
  parameter int unsigned MAX_LEVEL    = 32'd7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame,
  input  logic        shoot,
  input  logic [1:0]  lives,
  input  logic [54:0] invaders,
  input  logic [1:0]  player_collision,
  output logic [2:0]  state,
  output logic        play_en,
  output logic        freeze,
  output logic        game_over,
  output logic        round_rst,
  output logic        new_game,
  output logic [2:0]  level
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_HIT   = 3'd2,
    ST_CLEAR = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  localparam logic [7:0] HIT_LIM   = 8'(HIT_FRAMES);
  localparam logic [7:0] CLEAR_LIM = 8'(CLEAR_FRAMES);
  localparam logic [7:0] OVER_LIM  = 8'(OVER_FRAMES);
  localparam logic [2:0] MAX_LVL   = 3'(MAX_LEVEL);

  state_e     state_r, state_nxt_s;
  logic [7:0] cnt_r, cnt_nxt_s;
  logic       arm_r, arm_nxt_s;
  logic [2:0] level_r, level_nxt_s;
  logic       reload_s, new_game_s, state_chg_s;
  logic       play_en_r, freeze_r, game_over_r, round_rst_r, new_game_r;

  // Next-state, reload pulses, level update, frame counter and arm flag.
  always_comb begin
    state_nxt_s = state_r;
    reload_s    = 1'b0;
    new_game_s  = 1'b0;
    level_nxt_s = level_r;
    case (state_r)
      ST_IDLE: begin
        if (shoot) begin
          state_nxt_s = ST_PLAY;
          reload_s    = 1'b1;
          new_game_s  = 1'b1;
          level_nxt_s = 3'd0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PLAY: begin
        // Collision outranks wave-clear; clear is blind until the formation reloads.
        if (player_collision != 2'b00) begin
          state_nxt_s = ST_HIT;
        end else if (arm_r && (invaders == 55'd0)) begin
          state_nxt_s = ST_CLEAR;
        end else begin
          state_nxt_s = ST_PLAY;
        end
      end
      ST_HIT: begin
        if (cnt_r >= HIT_LIM) begin
          if (lives == 2'd0) begin
            state_nxt_s = ST_OVER;
          end else begin
            state_nxt_s = ST_PLAY;
          end
        end else begin
          state_nxt_s = ST_HIT;
        end
      end
      ST_CLEAR: begin
        if (cnt_r >= CLEAR_LIM) begin
          state_nxt_s = ST_PLAY;
          reload_s    = 1'b1;
          if (level_r >= MAX_LVL) begin
            level_nxt_s = level_r;
          end else begin
            level_nxt_s = level_r + 3'd1;
          end
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      ST_OVER: begin
        if ((cnt_r >= OVER_LIM) && shoot) begin
          state_nxt_s = ST_PLAY;
          reload_s    = 1'b1;
          new_game_s  = 1'b1;
          level_nxt_s = 3'd0;
        end else begin
          state_nxt_s = ST_OVER;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    state_chg_s = (state_nxt_s != state_r);

    // A frame landing on a transition cycle belongs to neither state.
    if (state_chg_s) begin
      cnt_nxt_s = 8'd0;
      arm_nxt_s = 1'b0;
    end else if (frame) begin
      if (cnt_r != 8'hFF) begin
        cnt_nxt_s = cnt_r + 8'd1;
      end else begin
        cnt_nxt_s = cnt_r;
      end
      if (state_r == ST_PLAY) begin
        arm_nxt_s = 1'b1;
      end else begin
        arm_nxt_s = arm_r;
      end
    end else begin
      cnt_nxt_s = cnt_r;
      arm_nxt_s = arm_r;
    end
  end

  // State, counters and every output flag are held in flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 8'd0;
      arm_r       <= 1'b0;
      level_r     <= 3'd0;
      play_en_r   <= 1'b0;
      freeze_r    <= 1'b0;
      game_over_r <= 1'b0;
      round_rst_r <= 1'b0;
      new_game_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      arm_r       <= arm_nxt_s;
      level_r     <= level_nxt_s;
      play_en_r   <= (state_nxt_s == ST_PLAY);
      freeze_r    <= (state_nxt_s == ST_HIT) || (state_nxt_s == ST_CLEAR);
      game_over_r <= (state_nxt_s == ST_OVER);
      round_rst_r <= reload_s;
      new_game_r  <= new_game_s;
    end
  end

  assign state     = state_r;
  assign play_en   = play_en_r;
  assign freeze    = freeze_r;
  assign game_over = game_over_r;
  assign round_rst = round_rst_r;
  assign new_game  = new_game_r;
  assign level     = level_r;

endmodule

// File: tb/tb_game_fsm.sv
// Self-checking bench for game_fsm: directed vector table, multi-cycle pause
// sequences and a randomized run against a rule-level reference model.
module tb_game_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame;
  logic        shoot;
  logic [1:0]  lives;
  logic [54:0] invaders;
  logic [1:0]  player_collision;
  logic [2:0]  state;
  logic        play_en, freeze, game_over, round_rst, new_game;
  logic [2:0]  level;

  int checks = 0;
  int errors = 0;

  game_fsm dut (
    .clk(clk), .rst(rst), .frame(frame), .shoot(shoot), .lives(lives),
    .invaders(invaders), .player_collision(player_collision),
    .state(state), .play_en(play_en), .freeze(freeze), .game_over(game_over),
    .round_rst(round_rst), .new_game(new_game), .level(level)
  );

  always #5 clk = ~clk;

  // Reference model: mode numbers follow the published state codes; pauses from a table.
  int m_mode, m_frames, m_level;
  bit m_arm, m_rr, m_ng;
  int pause_len [5] = '{0, 0, 60, 90, 120};

  task automatic model_reset();
    m_mode = 0; m_frames = 0; m_level = 0; m_arm = 1'b0; m_rr = 1'b0; m_ng = 1'b0;
  endtask

  task automatic model_advance(bit s, bit f, bit [1:0] lv, bit empty, bit [1:0] c);
    int nxt;
    nxt = m_mode; m_rr = 1'b0; m_ng = 1'b0;
    if (m_mode == 0) begin
      if (s) begin nxt = 1; m_rr = 1'b1; m_ng = 1'b1; m_level = 0; end
    end else if (m_mode == 1) begin
      if (c != 2'b00) nxt = 2;
      else if (m_arm && empty) nxt = 3;
    end else if (m_frames >= pause_len[m_mode]) begin
      if (m_mode == 2) nxt = (lv == 2'd0) ? 4 : 1;
      else if (m_mode == 3) begin
        nxt = 1; m_rr = 1'b1; m_level = (m_level < 7) ? m_level + 1 : 7;
      end else if (s) begin
        nxt = 1; m_rr = 1'b1; m_ng = 1'b1; m_level = 0;
      end
    end
    if (nxt != m_mode) begin
      m_mode = nxt; m_frames = 0; m_arm = 1'b0;
    end else if (f) begin
      if (m_frames < 255) m_frames++;
      if (m_mode == 1) m_arm = 1'b1;
    end
  endtask

  function automatic logic [10:0] dut_vec();
    return {state, play_en, freeze, game_over, round_rst, new_game, level};
  endfunction

  function automatic logic [10:0] mk(int st, bit rr, bit ng, int lvl);
    logic [2:0] s3, l3;
    s3 = 3'(st); l3 = 3'(lvl);
    return {s3, (st == 1), (st == 2) || (st == 3), (st == 4), rr, ng, l3};
  endfunction

  task automatic chk(string name, logic [10:0] exp);
    checks++;
    if (dut_vec() !== exp) begin
      errors++;
      $display("FAIL %s got st/pe/fz/go/rr/ng/lvl=%b expected %b", name, dut_vec(), exp);
    end
  endtask

  task automatic set_invaders(bit empty);
    logic [63:0] r;
    r = {$urandom, $urandom};
    if (empty) invaders = 55'd0;
    else invaders = r[54:0] | (55'd1 << $urandom_range(54, 0));
  endtask

  task automatic step(string name);
    bit s, f, e;
    bit [1:0] lv, c;
    s = shoot; f = frame; e = (invaders == 55'd0); lv = lives; c = player_collision;
    @(posedge clk);
    model_advance(s, f, lv, e, c);
    #1;
    chk(name, mk(m_mode, m_rr, m_ng, m_level));
  endtask

  task automatic pulse_frames(int n);
    for (int i = 0; i < n; i++) begin
      frame = 1'b1; step("pause");
      frame = 1'b0; step("pause");
    end
  endtask

  typedef struct {
    bit       shoot;
    bit       frame;
    bit       inv_empty;
    bit [1:0] coll;
    int       st;
    bit       rr;
    bit       ng;
    int       lvl;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{shoot:1'b1, frame:1'b0, inv_empty:1'b0, coll:2'b00, st:1, rr:1'b1, ng:1'b1, lvl:0};
    vecs[1] = '{shoot:1'b0, frame:1'b0, inv_empty:1'b1, coll:2'b00, st:1, rr:1'b0, ng:1'b0, lvl:0};
    vecs[2] = '{shoot:1'b1, frame:1'b0, inv_empty:1'b1, coll:2'b00, st:1, rr:1'b0, ng:1'b0, lvl:0};
    vecs[3] = '{shoot:1'b0, frame:1'b1, inv_empty:1'b1, coll:2'b00, st:1, rr:1'b0, ng:1'b0, lvl:0};
    vecs[4] = '{shoot:1'b0, frame:1'b0, inv_empty:1'b1, coll:2'b00, st:3, rr:1'b0, ng:1'b0, lvl:0};
    vecs[5] = '{shoot:1'b0, frame:1'b1, inv_empty:1'b1, coll:2'b00, st:3, rr:1'b0, ng:1'b0, lvl:0};

    rst = 1'b1; frame = 1'b0; shoot = 1'b0; lives = 2'd3;
    player_collision = 2'b00; set_invaders(1'b0);
    #2 rst = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 chk("reset", 11'd0);
    @(negedge clk) rst = 1'b1;

    // Directed table: start, arm latency, entry to CLEAR.
    for (int i = 0; i < 6; i++) begin
      shoot = vecs[i].shoot; frame = vecs[i].frame;
      set_invaders(vecs[i].inv_empty); player_collision = vecs[i].coll;
      step("table_model");
      chk($sformatf("vec%0d", i), mk(vecs[i].st, vecs[i].rr, vecs[i].ng, vecs[i].lvl));
    end
    shoot = 1'b0; frame = 1'b0;

    // CLEAR pause: one frame already counted by vec5, 89 more reach 90.
    pulse_frames(88);
    chk("clear_89", mk(3, 1'b0, 1'b0, 0));
    frame = 1'b1; step("clear_90f");
    chk("clear_90", mk(3, 1'b0, 1'b0, 0));
    frame = 1'b0; step("clear_exit");
    chk("clear_exit", mk(1, 1'b1, 1'b0, 1));
    step("clear_after");
    chk("clear_pulse_end", mk(1, 1'b0, 1'b0, 1));

    // Collision and empty wave together: collision wins.
    set_invaders(1'b0); frame = 1'b1; step("arm");
    frame = 1'b0; set_invaders(1'b1); player_collision = 2'b01; step("coll");
    chk("coll_priority", mk(2, 1'b0, 1'b0, 1));
    player_collision = 2'b00; set_invaders(1'b0); lives = 2'd2;
    pulse_frames(59);
    frame = 1'b1; step("hit_60f");
    chk("hit_60", mk(2, 1'b0, 1'b0, 1));
    frame = 1'b0; step("hit_exit");
    chk("hit_to_play", mk(1, 1'b0, 1'b0, 1));

    // Last life: lives sampled only at HIT exit.
    player_collision = 2'b10; step("coll2");
    player_collision = 2'b00; lives = 2'd3;
    pulse_frames(59);
    frame = 1'b1; step("hit2_60f");
    frame = 1'b0; lives = 2'd0; step("hit2_exit");
    chk("hit_to_over", mk(4, 1'b0, 1'b0, 1));
    lives = 2'd2;
    pulse_frames(50);
    shoot = 1'b1; step("over_shoot50");
    shoot = 1'b0;
    chk("over_shoot_50_ignored", mk(4, 1'b0, 1'b0, 1));
    pulse_frames(69);
    shoot = 1'b1; step("over_shoot119");
    shoot = 1'b0;
    chk("over_shoot_119_ignored", mk(4, 1'b0, 1'b0, 1));
    frame = 1'b1; step("over_120f");
    frame = 1'b0; shoot = 1'b1; step("over_restart");
    shoot = 1'b0;
    chk("over_restart", mk(1, 1'b1, 1'b1, 0));
    step("restart_after");
    chk("restart_pulse_end", mk(1, 1'b0, 1'b0, 0));

    // Eight clears: level climbs to 7 and saturates.
    for (int i = 0; i < 8; i++) begin
      set_invaders(1'b1);
      frame = 1'b1; step("lvl_arm");
      frame = 1'b0; step("lvl_enter");
      pulse_frames(90);
      chk($sformatf("level_after_clear%0d", i + 1), mk(1, 1'b1, 1'b0, (i + 1 < 7) ? i + 1 : 7));
    end

    // Reset in the middle of a CLEAR pause.
    frame = 1'b1; step("rc_arm");
    frame = 1'b0; step("rc_enter");
    pulse_frames(45);
    chk("rc_in_clear", mk(3, 1'b0, 1'b0, 7));
    #3 rst = 1'b0;
    #1 chk("rc_async", 11'd0);
    model_reset();
    @(posedge clk);
    #1 chk("rc_held", 11'd0);
    @(negedge clk) rst = 1'b1;
    set_invaders(1'b0);
    for (int i = 0; i < 4; i++) begin
      step("rc_release");
      chk("rc_no_pulse", 11'd0);
    end

    // Randomized run against the reference model.
    begin
      bit prev_f;
      prev_f = 1'b0;
      for (int i = 0; i < 15000; i++) begin
        frame = (!prev_f) && ($urandom_range(2, 0) == 0);
        prev_f = frame;
        shoot = ($urandom_range(7, 0) == 0);
        lives = 2'($urandom_range(3, 0));
        set_invaders($urandom_range(5, 0) == 0);
        player_collision = ($urandom_range(59, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
        step("random");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
